// File: rtl/ucie_ctl_sb_req_queue.sv
// Sideband request queue: buffers CTL message requests and issues them one at
// a time to the SB top, tracking busy until completion with an ack timeout.
module ucie_ctl_sb_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ACK_TO = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_vld,
  input  logic [4:0]    i_req_decode,
  input  logic [31:0]   i_req_cap,
  output logic          o_req_rdy,
  output logic          o_valid_lp_sb,
  output logic [4:0]    o_rdi_lp_sb_decode,
  output logic [31:0]   o_rdi_lp_adv_cap_value,
  input  logic          i_pl_sb_busy,
  output logic [CW-1:0] o_q_count,
  output logic          o_q_empty,
  output logic          o_ack_timeout,
  output logic          o_idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t         state, state_d;
  logic [TW-1:0]  ack_cnt, ack_cnt_d;
  logic [36:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop, timeout;
  logic           valid_q;
  logic [4:0]     dec_q;
  logic [31:0]    cap_q;

  assign o_req_rdy = (count != CW'(DEPTH));
  assign o_q_empty = (count == '0);
  assign push      = i_req_vld && o_req_rdy;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_req_decode, i_req_cap};
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d   = state;
    ack_cnt_d = ack_cnt;
    pop       = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!o_q_empty && !i_pl_sb_busy) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (i_pl_sb_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt == TW'(ACK_TO - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_pl_sb_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      ack_cnt <= '0;
      valid_q <= 1'b0;
      dec_q   <= '0;
      cap_q   <= '0;
    end else begin
      state   <= state_d;
      ack_cnt <= ack_cnt_d;
      valid_q <= (state_d == SEND);
      if (pop) {dec_q, cap_q} <= mem[rd_ptr];
    end
  end

  assign o_valid_lp_sb          = valid_q;
  assign o_rdi_lp_sb_decode     = dec_q;
  assign o_rdi_lp_adv_cap_value = cap_q;
  // Timeout is flagged in the final WAIT_ACK cycle itself
  assign o_ack_timeout          = timeout;
  assign o_q_count              = count;
  assign o_idle                 = (state == IDLE) && o_q_empty;

endmodule

// File: tb/tb_ucie_ctl_sb_req_queue.sv
// Bench for ucie_ctl_sb_req_queue: random payloads against a queue model,
// with issue timing checked from the documented latencies.
module tb_ucie_ctl_sb_req_queue;
  localparam int DEPTH  = 4;
  localparam int ACK_TO = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld;
  logic [4:0]    req_decode;
  logic [31:0]   req_cap;
  logic          req_rdy;
  logic          valid_lp;
  logic [4:0]    lp_decode;
  logic [31:0]   lp_cap;
  logic          busy;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          ack_timeout;
  logic          idle;

  int errors = 0;
  int checks = 0;

  logic [36:0] mq[$];
  logic        issued;
  logic [36:0] popped;

  ucie_ctl_sb_req_queue #(.DEPTH(DEPTH), .ACK_TO(ACK_TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_vld(req_vld), .i_req_decode(req_decode),
    .i_req_cap(req_cap), .o_req_rdy(req_rdy), .o_valid_lp_sb(valid_lp),
    .o_rdi_lp_sb_decode(lp_decode), .o_rdi_lp_adv_cap_value(lp_cap),
    .i_pl_sb_busy(busy), .o_q_count(q_count), .o_q_empty(q_empty),
    .o_ack_timeout(ack_timeout), .o_idle(idle)
  );

  always #5 clk = ~clk;

  // One clock: inputs set since the last negedge take effect at the posedge,
  // then the model is updated and outputs are visible at the next negedge.
  task automatic tick();
    bit          acc;
    logic [36:0] d;
    acc = req_vld && (mq.size() < DEPTH) && rst;
    d   = {req_decode, req_cap};
    @(negedge clk);
    issued = valid_lp;
    popped = 'x;
    if (issued && mq.size() > 0) popped = mq.pop_front();
    if (acc) mq.push_back(d);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    mq.delete();
    req_vld = 1'b0; busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_req();
    req_decode = 5'($urandom());
    req_cap    = $urandom();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (valid_lp !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_lp); end
    checks++; if (lp_decode !== 5'h0) begin errors++; $display("FAIL reset_decode: got %h want 0", lp_decode); end
    checks++; if (lp_cap !== 32'h0) begin errors++; $display("FAIL reset_cap: got %h want 0", lp_cap); end
    checks++; if (ack_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", ack_timeout); end
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", req_rdy); end
    checks++; if (q_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", q_count); end
    checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", q_empty); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    checks++; if (valid_lp !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL reset_release: got valid=%b idle=%b want 0/1", valid_lp, idle); end
  endtask

  task automatic test_single();
    bit bad_pulse = 0;
    hard_reset();
    req_vld = 1'b1; req_decode = 5'h0A; req_cap = 32'h1234_5678;
    tick();
    req_vld = 1'b0;
    checks++; if (valid_lp !== 1'b0 || q_count !== CW'(1)) begin errors++; $display("FAIL single_after_push: got valid=%b count=%0d want 0/1", valid_lp, q_count); end
    tick();
    checks++; if (valid_lp !== 1'b1) begin errors++; $display("FAIL single_latency: got valid=%b want 1", valid_lp); end
    checks++; if (lp_decode !== 5'h0A || lp_cap !== 32'h1234_5678) begin errors++; $display("FAIL single_data: got %h/%h want 0a/12345678", lp_decode, lp_cap); end
    checks++; if ({lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL single_model: got %h want %h", {lp_decode, lp_cap}, popped); end
    tick();
    checks++; if (valid_lp !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got valid=%b want 0", valid_lp); end
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid_lp || ack_timeout) bad_pulse = 1;
    end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got idle=%b want 0", idle); end
    busy = 1'b0;
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_return: got idle=%b want 1", idle); end
    checks++; if (bad_pulse) begin errors++; $display("FAIL single_spurious: got pulse=1 want 0"); end
  endtask

  task automatic test_fill();
    int n = 0, last = 0, resp = 0;
    bit to_seen = 0;
    hard_reset();
    busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      req_vld = 1'b1; rand_req();
      tick();
    end
    checks++; if (req_rdy !== 1'b0 || q_count !== CW'(DEPTH) || q_empty !== 1'b0) begin errors++; $display("FAIL fill_full: got rdy=%b count=%0d empty=%b want 0/4/0", req_rdy, q_count, q_empty); end
    rand_req();
    tick();
    req_vld = 1'b0;
    checks++; if (q_count !== CW'(DEPTH) || q_count !== CW'(mq.size())) begin errors++; $display("FAIL fill_ignored: got count=%0d want %0d", q_count, mq.size()); end
    busy = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (ack_timeout) to_seen = 1;
      if (issued) begin
        checks++; if ({lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL fill_order%0d: got %h want %h", n, {lp_decode, lp_cap}, popped); end
        if (n > 0) begin
          checks++; if (c - last != 4) begin errors++; $display("FAIL fill_spacing%0d: got %0d want 4", n, c - last); end
        end
        last = c; n++; resp = 1;
      end else if (resp == 1) begin busy = 1'b1; resp = 2; end
      else if (resp == 2) begin busy = 1'b0; resp = 0; end
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL fill_issues: got %0d want %0d", n, DEPTH); end
    checks++; if (q_empty !== 1'b1 || req_rdy !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL fill_drained: got empty=%b rdy=%b idle=%b want 1/1/1", q_empty, req_rdy, idle); end
    checks++; if (to_seen) begin errors++; $display("FAIL fill_timeout: got 1 want 0"); end
  endtask

  task automatic test_timeout();
    int k;
    bit found, vbad = 0;
    hard_reset();
    req_vld = 1'b1; rand_req();
    tick();
    rand_req();
    tick();
    req_vld = 1'b0;
    checks++; if (issued !== 1'b1 || {lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL to_first_issue: got valid=%b data=%h want 1/%h", issued, {lp_decode, lp_cap}, popped); end
    found = 0;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (valid_lp) vbad = 1;
      if (ack_timeout) begin found = 1; break; end
    end
    checks++; if (!found || k != ACK_TO) begin errors++; $display("FAIL to_latency: got %0d want %0d", found ? k : -1, ACK_TO); end
    checks++; if (vbad || q_count !== CW'(1)) begin errors++; $display("FAIL to_dropped: got revalid=%b count=%0d want 0/1", vbad, q_count); end
    tick();
    checks++; if (ack_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", ack_timeout); end
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (issued) begin
        found = 1;
        checks++; if ({lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL to_next_data: got %h want %h", {lp_decode, lp_cap}, popped); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL to_next_issue: got none want 1"); end
    found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      if (ack_timeout) found = 1;
    end
    tick();
    checks++; if (!found || idle !== 1'b1) begin errors++; $display("FAIL to_second: got timeout=%b idle=%b want 1/1", found, idle); end
  endtask

  task automatic test_wrap();
    int n = 0, resp = 0;
    hard_reset();
    busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_vld = 1'b1; rand_req();
      tick();
    end
    req_vld = 1'b0;
    checks++; if (q_count !== CW'(2)) begin errors++; $display("FAIL wrap_prefill: got %0d want 2", q_count); end
    for (int r = 0; r < 4; r++) begin
      busy = 1'b0; req_vld = 1'b1; rand_req();
      tick();
      req_vld = 1'b0;
      checks++; if (issued !== 1'b1 || {lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL wrap_issue%0d: got valid=%b data=%h want 1/%h", r, issued, {lp_decode, lp_cap}, popped); end
      checks++; if (q_count !== CW'(2) || q_count !== CW'(mq.size())) begin errors++; $display("FAIL wrap_count%0d: got %0d want 2", r, q_count); end
      tick(); busy = 1'b1;
      tick(); busy = 1'b0;
      tick(); busy = 1'b1;
      tick();
    end
    busy = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (issued) begin
        checks++; if ({lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL wrap_drain%0d: got %h want %h", n, {lp_decode, lp_cap}, popped); end
        n++; resp = 1;
      end else if (resp == 1) begin busy = 1'b1; resp = 2; end
      else if (resp == 2) begin busy = 1'b0; resp = 0; end
    end
    checks++; if (n != 2 || q_empty !== 1'b1) begin errors++; $display("FAIL wrap_final: got issues=%0d empty=%b want 2/1", n, q_empty); end
  endtask

  task automatic test_busy_idle();
    int n = 0, resp = 0;
    hard_reset();
    busy = 1'b1;
    req_vld = 1'b1; rand_req();
    tick();
    req_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (issued) n++;
    end
    checks++; if (n != 0 || q_count !== CW'(1)) begin errors++; $display("FAIL busy_block: got issues=%0d count=%0d want 0/1", n, q_count); end
    busy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (issued) begin
        checks++; if (c != 0 || {lp_decode, lp_cap} !== popped) begin errors++; $display("FAIL busy_release: got cyc=%0d data=%h want 0/%h", c, {lp_decode, lp_cap}, popped); end
        n++; resp = 1;
      end else if (resp == 1) begin busy = 1'b1; resp = 2; end
      else if (resp == 2) begin busy = 1'b0; resp = 0; end
    end
    checks++; if (n != 1 || idle !== 1'b1) begin errors++; $display("FAIL busy_once: got issues=%0d idle=%b want 1/1", n, idle); end
  endtask

  task automatic test_reset_mid();
    bit pulse = 0;
    hard_reset();
    for (int i = 0; i < 3; i++) begin
      req_vld = 1'b1; rand_req();
      tick();
    end
    req_vld = 1'b0;
    busy = 1'b1;
    tick(); tick();
    checks++; if (q_count !== CW'(2) || idle !== 1'b0) begin errors++; $display("FAIL mid_setup: got count=%0d idle=%b want 2/0", q_count, idle); end
    #2 rst = 1'b0;
    mq.delete();
    busy = 1'b0;
    #1;
    checks++; if (q_count !== '0 || idle !== 1'b1 || valid_lp !== 1'b0) begin errors++; $display("FAIL mid_in_reset: got count=%0d idle=%b valid=%b want 0/1/0", q_count, idle, valid_lp); end
    checks++; if (lp_decode !== 5'h0 || lp_cap !== 32'h0) begin errors++; $display("FAIL mid_data_clear: got %h/%h want 0/0", lp_decode, lp_cap); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (valid_lp || ack_timeout) pulse = 1;
    end
    checks++; if (pulse) begin errors++; $display("FAIL mid_no_pulse: got pulse=1 want 0"); end
    checks++; if (q_count !== '0 || idle !== 1'b1) begin errors++; $display("FAIL mid_after: got count=%0d idle=%b want 0/1", q_count, idle); end
  endtask

  initial begin
    rst = 1'b0; req_vld = 1'b0; req_decode = '0; req_cap = '0; busy = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_wrap();
    test_busy_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
